// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, FSM state and next-PC select encodings for the MIPS fetch path.
package mips_pkg;
    localparam int PC_W = 16;
    localparam int INSTR_BYTES = 2;
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10} state_e;
    typedef enum logic [2:0] {SEL_HOLD, SEL_JUMP, SEL_BRANCH, SEL_SEQ, SEL_WRAP} pc_sel_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: redirect requests from decode and fetch-side status of the PC sequencer.
interface pc_sequencer_if;
    import mips_pkg::*;
    logic run, stall, halt, jump, branch;
    logic [PC_W-1:0] jump_address, branch_offset, pc_out, retired;
    logic pc_valid, redirect, align_err;
    logic [1:0] state;
    modport master (
        output run, stall, halt, jump, branch, jump_address, branch_offset,
        input pc_out, pc_valid, redirect, retired, align_err, state
    );
    modport slave (
        input run, stall, halt, jump, branch, jump_address, branch_offset,
        output pc_out, pc_valid, redirect, retired, align_err, state
    );
endinterface

// File: rtl/pc_next_gen.sv
// pc_next_gen: next-PC priority select (halt > jump > branch > sequential/wrap) and jump alignment check.
module pc_next_gen
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter logic [PC_W-1:0] PROG_END = 16'd30
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic            halt_i,
    input  logic            jump_i,
    input  logic            branch_i,
    input  logic [PC_W-1:0] jump_address_i,
    input  logic [PC_W-1:0] branch_offset_i,
    output logic [PC_W-1:0] pc_o,
    output pc_sel_e         sel_o,
    output logic            misalign_o
);
    logic [PC_W-1:0] seq_pc;
    always_comb begin
        seq_pc = pc_i + PC_W'(INSTR_BYTES);
        sel_o = halt_i ? SEL_HOLD : jump_i ? SEL_JUMP : branch_i ? SEL_BRANCH :
                (pc_i >= PROG_END) ? SEL_WRAP : SEL_SEQ;
        pc_o = (sel_o == SEL_HOLD)   ? pc_i :
               (sel_o == SEL_JUMP)   ? {jump_address_i[PC_W-1:1], 1'b0} :
               (sel_o == SEL_BRANCH) ? seq_pc + (branch_offset_i << 1) :
               (sel_o == SEL_WRAP)   ? RESET_VEC : seq_pc;
        misalign_o = (sel_o == SEL_JUMP) && jump_address_i[0];
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, run-control FSM and retired-instruction counter for the 16-bit MIPS core.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter logic [PC_W-1:0] PROG_END = 16'd30
) (
    input logic          clk,
    input logic          rst,
    pc_sequencer_if.slave bus
);
    state_e          state_q;
    pc_sel_e         sel;
    logic [PC_W-1:0] pc_q, pc_d, retired_q;
    logic            redirect_q, align_q, misalign, in_run, commit;
    assign in_run = state_q == RUN;
    assign commit = in_run && !bus.stall;
    // Controls are masked outside RUN so a HALT resume takes the plain sequential step.
    pc_next_gen #(.RESET_VEC(RESET_VEC), .PROG_END(PROG_END)) u_next (
        .pc_i(pc_q),
        .halt_i(in_run && bus.halt),
        .jump_i(in_run && bus.jump),
        .branch_i(in_run && bus.branch),
        .jump_address_i(bus.jump_address),
        .branch_offset_i(bus.branch_offset),
        .pc_o(pc_d),
        .sel_o(sel),
        .misalign_o(misalign)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VEC;
            redirect_q <= 1'b0;
            retired_q  <= '0;
            align_q    <= 1'b0;
        end else if (commit) begin
            pc_q       <= pc_d;
            redirect_q <= (sel == SEL_JUMP) || (sel == SEL_BRANCH);
            retired_q  <= retired_q + PC_W'(1);
            align_q    <= align_q | misalign;
            if (bus.halt) state_q <= HALT;
        end else if (!in_run && bus.run) begin
            state_q <= RUN;
            if (state_q == HALT) pc_q <= pc_d;
        end
    end
    assign bus.pc_out    = pc_q;
    assign bus.pc_valid  = in_run;
    assign bus.redirect  = redirect_q;
    assign bus.retired   = retired_q;
    assign bus.align_err = align_q;
    assign bus.state     = state_q;
endmodule
